// File: rtl/s344_seq_pkg.sv
// Shared types and constants for the s344 operand sequencer.
package s344_seq_pkg;

   localparam int OPW          = 4;  // operand width
   localparam int PW           = 8;  // product width
   localparam int READY_IGNORE = 1;  // cycles after START where s344 READY is stale

   typedef enum logic [2:0] {
      ST_INIT_ISSUE = 3'd0,
      ST_INIT_WAIT  = 3'd1,
      ST_IDLE       = 3'd2,
      ST_ISSUE      = 3'd3,
      ST_WAIT       = 3'd4
   } state_t;

   // Packs an operand pair into one FIFO word, A in the upper nibble.
   function automatic logic [2*OPW-1:0] pack_ops(input logic [OPW-1:0] a,
                                                 input logic [OPW-1:0] b);
      return {a, b};
   endfunction

endpackage

// File: rtl/s344_seq_fifo.sv
// Synchronous operand FIFO: DEPTH entries of packed {A,B}, head is read combinationally.
module s344_seq_fifo
   import s344_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [2*OPW-1:0]         wdata_i,
   output logic [2*OPW-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [2*OPW-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;

   // Next pointer and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers, cleared by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/s344_seq.sv
// Operand sequencer and product capture wrapped around the s344 shift-add multiplier.
module s344_seq
   import s344_seq_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int WAIT_MAX = 8
) (
   input  logic                    CK,
   input  logic                    RST,
   input  logic                    IN_VALID,
   input  logic [OPW-1:0]          IN_A,
   input  logic [OPW-1:0]          IN_B,
   output logic                    IN_READY,
   output logic                    START,
   output logic [OPW-1:0]          A,
   output logic [OPW-1:0]          B,
   input  logic                    READY,
   input  logic [PW-1:0]           P,
   output logic                    OUT_VALID,
   output logic [PW-1:0]           OUT_P,
   input  logic                    OUT_READY,
   output logic [$clog2(DEPTH):0]  COUNT,
   output logic                    ERR
);

   localparam int WCW = $clog2(WAIT_MAX + 1);

   state_t            state_q;
   logic              start_q;
   logic [OPW-1:0]    a_q;
   logic [OPW-1:0]    b_q;
   logic              out_valid_q;
   logic [PW-1:0]     out_p_q;
   logic              err_q;
   logic [WCW-1:0]    wait_cnt_q;

   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [2*OPW-1:0]  fifo_head_s;
   logic              issue_ok_s;
   logic              pop_s;
   logic              ready_seen_s;
   logic              timeout_s;

   s344_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (CK),
      .rst_i   (RST),
      .push_i  (IN_VALID),
      .pop_i   (pop_s),
      .wdata_i (pack_ops(IN_A, IN_B)),
      .rdata_o (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (COUNT)
   );

   // An operand may be issued when one is queued and the output slot is free next cycle.
   always_comb begin
      issue_ok_s = 1'b0;
      if (!fifo_empty_s && (!out_valid_q || OUT_READY)) begin
         issue_ok_s = 1'b1;
      end else begin
         issue_ok_s = 1'b0;
      end
   end

   assign pop_s        = (state_q == ST_IDLE) && issue_ok_s;
   assign ready_seen_s = READY && (wait_cnt_q > WCW'(READY_IGNORE));
   assign timeout_s    = (wait_cnt_q >= WCW'(WAIT_MAX));

   // start_q is preloaded during reset so the dummy START appears in the first
   // post-reset cycle; masking with RST keeps START low while reset is held.
   assign IN_READY  = ~fifo_full_s;
   assign START     = start_q & ~RST;
   assign A         = a_q;
   assign B         = b_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_P     = out_p_q;
   assign ERR       = err_q;

   // Sequencer FSM with operand registers, timeout counter and output slot.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q     <= ST_INIT_ISSUE;
         start_q     <= 1'b1;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         err_q       <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         // Acceptance frees the slot; a capture below in the same cycle overrides it.
         if (out_valid_q && OUT_READY) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            ST_INIT_ISSUE: begin
               start_q    <= 1'b0;
               wait_cnt_q <= WCW'(1);
               state_q    <= ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
               if (ready_seen_s) begin
                  state_q <= ST_IDLE;
               end else if (timeout_s) begin
                  err_q   <= 1'b1;
                  start_q <= 1'b1;
                  state_q <= ST_INIT_ISSUE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WCW'(1);
               end
            end
            ST_IDLE: begin
               if (issue_ok_s) begin
                  a_q     <= fifo_head_s[2*OPW-1:OPW];
                  b_q     <= fifo_head_s[OPW-1:0];
                  start_q <= 1'b1;
                  state_q <= ST_ISSUE;
               end else begin
                  start_q <= 1'b0;
               end
            end
            ST_ISSUE: begin
               start_q    <= 1'b0;
               wait_cnt_q <= WCW'(1);
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ready_seen_s) begin
                  out_p_q     <= P;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else if (timeout_s) begin
                  // The in-flight operand is abandoned; the FIFO keeps its contents.
                  err_q   <= 1'b1;
                  start_q <= 1'b1;
                  state_q <= ST_INIT_ISSUE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WCW'(1);
               end
            end
            default: begin
               start_q <= 1'b1;
               state_q <= ST_INIT_ISSUE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_s344_seq.sv
// Self-checking bench for s344_seq with a behavioural s344 multiplier model.
module tb_s344_seq;

   localparam int DEPTH    = 4;
   localparam int WAIT_MAX = 8;

   logic       CK = 1'b0;
   logic       RST = 1'b1;
   logic       IN_VALID = 1'b0;
   logic [3:0] IN_A = 4'd0;
   logic [3:0] IN_B = 4'd0;
   logic       IN_READY;
   logic       START;
   logic [3:0] A;
   logic [3:0] B;
   logic       READY;
   logic [7:0] P;
   logic       OUT_VALID;
   logic [7:0] OUT_P;
   logic       OUT_READY = 1'b1;
   logic [2:0] COUNT;
   logic       ERR;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [7:0] exp_q [$];

   // s344 model: cycles since START; READY stale-high one cycle, low for 4, high from 6.
   logic [3:0] ss = 4'd15;
   logic [3:0] la = 4'd0;
   logic [3:0] lb = 4'd0;
   logic       force_low = 1'b0;

   always #5 CK = ~CK;

   always @(posedge CK) cyc <= cyc + 1;

   always @(posedge CK) begin
      if (START) begin
         ss <= 4'd1;
         la <= A;
         lb <= B;
      end else if (ss < 4'd15) begin
         ss <= ss + 4'd1;
      end
   end

   assign READY = !force_low && (ss == 4'd1 || ss >= 4'd6);
   assign P     = (ss >= 4'd6) ? (8'(la) * 8'(lb)) : 8'h5A;

   s344_seq #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
      .CK        (CK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_A      (IN_A),
      .IN_B      (IN_B),
      .IN_READY  (IN_READY),
      .START     (START),
      .A         (A),
      .B         (B),
      .READY     (READY),
      .P         (P),
      .OUT_VALID (OUT_VALID),
      .OUT_P     (OUT_P),
      .OUT_READY (OUT_READY),
      .COUNT     (COUNT),
      .ERR       (ERR)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] b,
                       input logic exp_acc, input logic add_sb);
      IN_VALID = 1'b1;
      IN_A     = a;
      IN_B     = b;
      chk("in_ready", 32'(IN_READY), 32'(exp_acc));
      tick();
      if (exp_acc && add_sb) exp_q.push_back(8'(a) * 8'(b));
      IN_VALID = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int bound, output int sc);
      int n;
      n = 0;
      while (START !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(START), 32'd1);
      sc = cyc;
   endtask

   task automatic wait_valid(input string tag, input int bound);
      int n;
      n = 0;
      while (OUT_VALID !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(OUT_VALID), 32'd1);
   endtask

   task automatic drain(input string tag, input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || OUT_VALID === 1'b1) && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Output monitor: every transfer is matched against the scoreboard; stalled data must hold.
   initial begin
      logic       hold_prev;
      logic [7:0] prev_p;
      logic [7:0] e;
      hold_prev = 1'b0;
      prev_p    = 8'd0;
      forever begin
         @(negedge CK);
         if (RST) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev) begin
               chk("out_hold_valid", 32'(OUT_VALID), 32'd1);
               chk("out_hold_p", 32'(OUT_P), 32'(prev_p));
            end
            if (OUT_VALID === 1'b1 && OUT_READY) begin
               if (exp_q.size() == 0) begin
                  chk("out_unexpected", 32'(OUT_VALID), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("product", 32'(OUT_P), 32'(e));
               end
            end
            hold_prev = (OUT_VALID === 1'b1) && !OUT_READY;
            prev_p    = OUT_P;
         end
      end
   end

   initial begin
      int r, s, s2, cap, w;
      logic acc;

      // Reset and the first post-reset cycle.
      RST = 1'b1;
      tick();
      tick();
      chk("rst_start", 32'(START), 32'd0);
      chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_count", 32'(COUNT), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_out_p", 32'(OUT_P), 32'd0);
      RST = 1'b0;
      #1;
      chk("post_rst_start", 32'(START), 32'd1);
      chk("post_rst_a", 32'(A), 32'd0);
      chk("post_rst_b", 32'(B), 32'd0);
      chk("post_rst_in_ready", 32'(IN_READY), 32'd1);

      // (3,5) pushed during INIT: issued after the dummy, product at START+7.
      r = cyc;
      push(4'd3, 4'd5, 1'b1, 1'b1);
      wait_start("t1_start", 20, s);
      chk("t1_start_delay", 32'(s - r), 32'd8);
      chk("t1_a", 32'(A), 32'd3);
      chk("t1_b", 32'(B), 32'd5);
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk("t1_no_valid", 32'(OUT_VALID), 32'd0);
         if (i == 1) chk("t1_start_pulse", 32'(START), 32'd0);
      end
      tick();
      chk("t1_valid", 32'(OUT_VALID), 32'd1);
      chk("t1_p", 32'(OUT_P), 32'h0F);
      tick();

      // Back-to-back operands with the consumer always ready.
      push(4'd15, 4'd15, 1'b1, 1'b1);
      push(4'd0, 4'd9, 1'b1, 1'b1);
      wait_start("t2_start_a", 20, s);
      chk("t2_a1", 32'(A), 32'd15);
      chk("t2_b1", 32'(B), 32'd15);
      tick();
      wait_start("t2_start_b", 20, s2);
      chk("t2_period", 32'(s2 - s), 32'd8);
      chk("t2_a2", 32'(A), 32'd0);
      chk("t2_b2", 32'(B), 32'd9);
      drain("t2_drain", 50);

      // Consumer stalls: no second START until acceptance, then the very next cycle.
      OUT_READY = 1'b0;
      push(4'd1, 4'd2, 1'b1, 1'b1);
      push(4'd3, 4'd4, 1'b1, 1'b1);
      push(4'd5, 4'd6, 1'b1, 1'b1);
      wait_valid("t3_valid", 20);
      cap = cyc;
      chk("t3_p", 32'(OUT_P), 32'd2);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_no_start", 32'(START), 32'd0);
      end
      chk("t3_count", 32'(COUNT), 32'd2);
      OUT_READY = 1'b1;
      w = cyc;
      tick();
      chk("t3_start_after_accept", 32'(START), 32'd1);
      chk("t3_start_cycle", 32'(cyc - w), 32'd1);
      chk("t3_a2", 32'(A), 32'd3);
      chk("t3_b2", 32'(B), 32'd4);
      drain("t3_drain", 60);

      // FIFO fill with no pops possible: four accepted, the fifth refused.
      OUT_READY = 1'b0;
      push(4'd2, 4'd3, 1'b1, 1'b1);
      wait_valid("t4_valid", 20);
      for (int i = 0; i < 5; i++) begin
         acc = (i < 4);
         push(4'(4 + i), 4'(9 + i), acc, 1'b1);
      end
      chk("t4_count_full", 32'(COUNT), 32'd4);
      chk("t4_in_ready_full", 32'(IN_READY), 32'd0);
      OUT_READY = 1'b1;
      drain("t4_drain", 200);
      chk("t4_count_empty", 32'(COUNT), 32'd0);

      // Timeout: READY withheld, ERR at START+9 with re-init START; queued operand survives.
      force_low = 1'b1;
      push(4'd7, 4'd9, 1'b1, 1'b0);
      wait_start("t5_start", 10, s);
      tick();
      tick();
      push(4'd2, 4'd6, 1'b1, 1'b1);
      repeat (5) tick();
      chk("t5_err_before", 32'(ERR), 32'd0);
      chk("t5_count_wait", 32'(COUNT), 32'd1);
      tick();
      chk("t5_err_at_timeout", 32'(ERR), 32'd1);
      chk("t5_reinit_start", 32'(START), 32'd1);
      chk("t5_err_cycle", 32'(cyc - s), 32'(WAIT_MAX + 1));
      chk("t5_count_kept", 32'(COUNT), 32'd1);
      force_low = 1'b0;
      tick();
      wait_start("t5_start_next", 20, s2);
      chk("t5_next_delay", 32'(s2 - s), 32'd17);
      chk("t5_a", 32'(A), 32'd2);
      chk("t5_b", 32'(B), 32'd6);
      drain("t5_drain", 50);
      chk("t5_err_sticky", 32'(ERR), 32'd1);

      // Reset while in WAIT.
      push(4'd4, 4'd4, 1'b1, 1'b0);
      push(4'd1, 4'd1, 1'b1, 1'b0);
      wait_start("t6_start", 10, s);
      repeat (3) tick();
      RST = 1'b1;
      tick();
      exp_q.delete();
      chk("t6_out_valid", 32'(OUT_VALID), 32'd0);
      chk("t6_count", 32'(COUNT), 32'd0);
      chk("t6_err", 32'(ERR), 32'd0);
      RST = 1'b0;
      #1;
      chk("t6_dummy_start", 32'(START), 32'd1);
      chk("t6_a", 32'(A), 32'd0);
      chk("t6_b", 32'(B), 32'd0);

      // Randomized traffic with handshake noise on both sides.
      for (int i = 0; i < 400; i++) begin
         IN_VALID  = ($urandom_range(0, 2) == 0);
         IN_A      = 4'($urandom_range(0, 15));
         IN_B      = 4'($urandom_range(0, 15));
         OUT_READY = ($urandom_range(0, 3) != 0);
         acc       = IN_VALID && IN_READY;
         tick();
         if (acc) exp_q.push_back(8'(IN_A) * 8'(IN_B));
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      drain("rand_drain", 400);
      chk("rand_err", 32'(ERR), 32'd0);
      chk("rand_count", 32'(COUNT), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
